// File: rtl/btn_debounce_rpt.sv
// Pushbutton debouncer: 2-flop synchronizer, sample-tick FSM, registered level and press tick.
// Define BTN_DEBOUNCE_RPT_AUTO_REPEAT_EN to add auto-repeat ticks while the button is held.
module btn_debounce_rpt #(
    parameter int N        = 19,
    parameter int RPT_DLY  = 50,
    parameter int RPT_RATE = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    // Bit 2 set marks every state in which the debounced level is high.
    localparam logic [2:0] ZERO = 3'd0;
    localparam logic [2:0] W1_1 = 3'd1;
    localparam logic [2:0] W1_2 = 3'd2;
    localparam logic [2:0] W1_3 = 3'd3;
    localparam logic [2:0] ONE  = 3'd4;
    localparam logic [2:0] W0_1 = 3'd5;
    localparam logic [2:0] W0_2 = 3'd6;
    localparam logic [2:0] W0_3 = 3'd7;

    if (RPT_DLY < 1 || RPT_DLY > 255 || RPT_RATE < 1 || RPT_RATE > 255) begin : g_bad_rpt
        $error("btn_debounce_rpt: RPT_DLY and RPT_RATE must be in 1..255");
    end

    logic         sync_p0;
    logic         sw_s;
    logic [N-1:0] smp_cnt;
    logic         m_tick;
    logic [2:0]   state;
    logic [2:0]   state_nxt;
    logic         press;
    logic         tick_nxt;

    // Stage p0 -> sw_s: metastability filter on the raw button
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sw_s    <= 1'b0;
        end else begin
            sync_p0 <= sw;
            sw_s    <= sync_p0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) smp_cnt <= '0;
        else       smp_cnt <= smp_cnt + 1'b1;
    end

    assign m_tick = &smp_cnt;

    // A reversal of sw_s is tested before m_tick, so it wins in every wait state.
    always_comb begin
        state_nxt = state;
        press     = 1'b0;
        case (state)
            ZERO: if (sw_s) state_nxt = W1_1;
            W1_1: if (!sw_s) state_nxt = ZERO; else if (m_tick) state_nxt = W1_2;
            W1_2: if (!sw_s) state_nxt = ZERO; else if (m_tick) state_nxt = W1_3;
            W1_3: begin
                if (!sw_s) state_nxt = ZERO;
                else if (m_tick) begin
                    state_nxt = ONE;
                    press     = 1'b1;
                end
            end
            ONE:  if (!sw_s) state_nxt = W0_1;
            W0_1: if (sw_s) state_nxt = ONE; else if (m_tick) state_nxt = W0_2;
            W0_2: if (sw_s) state_nxt = ONE; else if (m_tick) state_nxt = W0_3;
            W0_3: if (sw_s) state_nxt = ONE; else if (m_tick) state_nxt = ZERO;
            default: state_nxt = ZERO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ZERO;
        else       state <= state_nxt;
    end

`ifdef BTN_DEBOUNCE_RPT_AUTO_REPEAT_EN
    localparam logic [7:0] RPT_DLY_C  = 8'(RPT_DLY);
    localparam logic [7:0] RPT_RELOAD = 8'(RPT_DLY - RPT_RATE);

    logic [7:0] rpt_cnt;
    logic       rpt_hit;

    assign rpt_hit = (state == ONE) && m_tick && ((rpt_cnt + 8'd1) == RPT_DLY_C);

    // Counter holds in W0_k so a bounce-back resumes the repeat cadence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_cnt <= 8'd0;
        end else if (press || state_nxt == ZERO) begin
            rpt_cnt <= 8'd0;
        end else if (state == ONE && m_tick) begin
            rpt_cnt <= rpt_hit ? RPT_RELOAD : rpt_cnt + 8'd1;
        end
    end

    assign tick_nxt = press | rpt_hit;
`else
    assign tick_nxt = press;
`endif

    // Registered outputs, aligned with the state register update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_level <= 1'b0;
            db_tick  <= 1'b0;
        end else begin
            db_level <= state_nxt[2];
            db_tick  <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_btn_debounce_rpt.sv
// Scoreboard bench for btn_debounce_rpt with N=4, RPT_DLY=3, RPT_RATE=2.
module tb_btn_debounce_rpt;

    localparam int K_TICK = 0;
    localparam int K_RISE = 1;
    localparam int K_FALL = 2;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sw = 1'b0;
    logic db_level;
    logic db_tick;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic prev_lvl = 1'b0;
    ev_t  exp_q[$];

    btn_debounce_rpt #(.N(4), .RPT_DLY(3), .RPT_RATE(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    always #5 clk = ~clk;

    function automatic string kname(input int k);
        case (k)
            K_TICK:  return "tick";
            K_RISE:  return "rise";
            default: return "fall";
        endcase
    endfunction

    task automatic push_ev(input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: got %s at cyc %0d, required no event", kname(kind), kname(kind), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL event_%s: got %s at cyc %0d, required %s at cyc %0d",
                         kname(e.kind), kname(kind), cyc, kname(e.kind), e.cyc);
            end
        end
    endtask

    task automatic check_val(input string name, input logic act, input logic req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic go_to(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    // Monitor: cyc counts rising edges since reset release; outputs sampled 1 ns after the edge
    always @(posedge clk) begin
        #1;
        if (reset) begin
            cyc      = 0;
            prev_lvl = 1'b0;
        end else begin
            cyc = cyc + 1;
            if (db_tick) check_ev(K_TICK);
            if (db_level !== prev_lvl) check_ev(db_level ? K_RISE : K_FALL);
            prev_lvl = db_level;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_val("reset_level", db_level, 1'b0);
        check_val("reset_tick", db_tick, 1'b0);
        reset = 1'b0;

        // Clean press at cyc 5: W1_1 at 8, tick boundaries 16/32/48
        go_to(5);
        sw = 1'b1;
        push_ev(K_TICK, 48);
        push_ev(K_RISE, 48);
`ifdef BTN_DEBOUNCE_RPT_AUTO_REPEAT_EN
        push_ev(K_TICK, 96);
`endif
        go_to(105);
        sw = 1'b0;
        push_ev(K_FALL, 144);

        // Bounce: toggle every 5 clocks for 60 clocks, expect nothing
        for (int i = 0; i < 12; i++) begin
            go_to(160 + 5 * i);
            sw = (i % 2 == 0);
        end
        go_to(220);
        sw = 1'b0;

        // Release bounce spanning one sample tick, then final release
        go_to(260);
        sw = 1'b1;
        push_ev(K_TICK, 304);
        push_ev(K_RISE, 304);
`ifdef BTN_DEBOUNCE_RPT_AUTO_REPEAT_EN
        push_ev(K_TICK, 368);
`endif
        go_to(330);
        sw = 1'b0;
        go_to(340);
        sw = 1'b1;
        go_to(372);
        sw = 1'b0;
        push_ev(K_FALL, 416);

        // Long hold for auto-repeat
        go_to(440);
        sw = 1'b1;
        push_ev(K_TICK, 480);
        push_ev(K_RISE, 480);
`ifdef BTN_DEBOUNCE_RPT_AUTO_REPEAT_EN
        for (int i = 0; i < 8; i++) push_ev(K_TICK, 528 + 32 * i);
`endif
        go_to(780);
        sw = 1'b0;
        push_ev(K_FALL, 816);

        // Reset while in W1_2 (entered at 848), sw stays high
        go_to(840);
        sw = 1'b1;
        go_to(850);
        reset = 1'b1;
        #1;
        check_val("rst_w12_level", db_level, 1'b0);
        check_val("rst_w12_tick", db_tick, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_ev(K_TICK, 48);
        push_ev(K_RISE, 48);

        // Reset while in ONE
        go_to(60);
        reset = 1'b1;
        #1;
        check_val("rst_one_level", db_level, 1'b0);
        check_val("rst_one_tick", db_tick, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_ev(K_TICK, 48);
        push_ev(K_RISE, 48);
`ifdef BTN_DEBOUNCE_RPT_AUTO_REPEAT_EN
        push_ev(K_TICK, 96);
`endif
        go_to(100);
        sw = 1'b0;
        push_ev(K_FALL, 144);

        // Release lands on the m_tick cycle in W1_3 (W1_3 from 192, tick at 208)
        go_to(160);
        sw = 1'b1;
        go_to(205);
        sw = 1'b0;
        go_to(260);

        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d outstanding, required 0 (next %s at cyc %0d)",
                     exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
